// File: rtl/alu_fu.sv
// Pipelined integer ALU functional unit. The result is computed on entry and then delayed
// through LAT registered stages. The pipeline stalls as a whole under CDB backpressure.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_SLL  4'd5
`define ALU_SRL  4'd6
`define ALU_SLT  4'd7
`define ALU_SLTU 4'd8
`define ALU_SRA  4'd9
`define ALU_AP4  4'd10
`define ALU_OUTB 4'd11
`endif

module alu_fu #(
  parameter int XLEN  = 32,
  parameter int TAG_W = `ROB_ENTRY_WIDTH,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             busy
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_ap4;
  logic [XLEN-1:0] w_res;
  logic            w_ovf;
  logic            w_stall;
  logic [LAT-1:0]  w_valid_vec;

  assign w_shamt = in_b[SHW-1:0];
  assign w_sum   = in_a + in_b;
  assign w_diff  = in_a - in_b;
  assign w_ap4   = in_a + XLEN'(4);

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (in_op)
      `ALU_ADD: begin
        w_res = w_sum;
        w_ovf = (in_a[XLEN-1] == in_b[XLEN-1]) && (w_sum[XLEN-1] != in_a[XLEN-1]);
      end
      `ALU_SUB: begin
        w_res = w_diff;
        w_ovf = (in_a[XLEN-1] != in_b[XLEN-1]) && (w_diff[XLEN-1] != in_a[XLEN-1]);
      end
      `ALU_AND:  w_res = in_a & in_b;
      `ALU_OR:   w_res = in_a | in_b;
      `ALU_XOR:  w_res = in_a ^ in_b;
      `ALU_SLL:  w_res = in_a << w_shamt;
      `ALU_SRL:  w_res = in_a >> w_shamt;
      `ALU_SRA:  w_res = $unsigned($signed(in_a) >>> w_shamt);
      `ALU_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      `ALU_SLTU: w_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      `ALU_AP4: begin
        // The constant 4 is non-negative, so overflow means a positive a wrapped negative.
        w_res = w_ap4;
        w_ovf = !in_a[XLEN-1] && w_ap4[XLEN-1];
      end
      `ALU_OUTB: w_res = in_b;
      default:   w_res = '0;
    endcase
  end

  // A stall freezes every stage, including empty ones, so bubbles never collapse.
  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      logic             r_valid;
      logic [XLEN-1:0]  r_res;
      logic [TAG_W-1:0] r_tag;
      logic             r_ovf;

      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_valid <= 1'b0;
            r_res   <= '0;
            r_tag   <= '0;
            r_ovf   <= 1'b0;
          end else if (flush) begin
            r_valid <= 1'b0;
          end else if (!w_stall) begin
            r_valid <= in_valid;
            r_res   <= w_res;
            r_tag   <= in_tag;
            r_ovf   <= w_ovf;
          end
        end
      end else begin : g_delay
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_valid <= 1'b0;
            r_res   <= '0;
            r_tag   <= '0;
            r_ovf   <= 1'b0;
          end else if (flush) begin
            r_valid <= 1'b0;
          end else if (!w_stall) begin
            r_valid <= g_stage[gi-1].r_valid;
            r_res   <= g_stage[gi-1].r_res;
            r_tag   <= g_stage[gi-1].r_tag;
            r_ovf   <= g_stage[gi-1].r_ovf;
          end
        end
      end

      assign w_valid_vec[gi] = r_valid;
    end
  endgenerate

  assign out_valid = g_stage[LAT-1].r_valid;
  assign out_res   = g_stage[LAT-1].r_res;
  assign out_tag   = g_stage[LAT-1].r_tag;
  assign out_ovf   = g_stage[LAT-1].r_ovf;
  assign out_zero  = (out_res == '0);
  assign busy      = |w_valid_vec;

endmodule

// File: tb/tb_alu_fu.sv
// Directed testbench for alu_fu: a LAT=2/XLEN=32 instance and a LAT=1/XLEN=64 instance.
`timescale 1ns/1ps
module tb_alu_fu;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SLT = 4'd7,
                         OP_SLTU = 4'd8, OP_SRA = 4'd9, OP_AP4 = 4'd10, OP_OUTB = 4'd11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [3:0]  a_in_op;
  logic [31:0] a_in_a, a_in_b, a_out_res;
  logic [5:0]  a_in_tag, a_out_tag;
  logic        a_out_zero, a_out_ovf, a_busy;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [3:0]  b_in_op;
  logic [63:0] b_in_a, b_in_b, b_out_res;
  logic [5:0]  b_in_tag, b_out_tag;
  logic        b_out_zero, b_out_ovf, b_busy;

  alu_fu #(.XLEN(32), .TAG_W(6), .LAT(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op),
    .in_a(a_in_a), .in_b(a_in_b), .in_tag(a_in_tag), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_res(a_out_res),
    .out_tag(a_out_tag), .out_zero(a_out_zero), .out_ovf(a_out_ovf), .busy(a_busy)
  );

  alu_fu #(.XLEN(64), .TAG_W(6), .LAT(1)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
    .in_a(b_in_a), .in_b(b_in_b), .in_tag(b_in_tag), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_res(b_out_res),
    .out_tag(b_out_tag), .out_zero(b_out_zero), .out_ovf(b_out_ovf), .busy(b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag);
    a_in_valid = 1'b1; a_in_op = op; a_in_a = a; a_in_b = b; a_in_tag = tag;
  endtask

  task automatic drive_b(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] tag);
    b_in_valid = 1'b1; b_in_op = op; b_in_a = a; b_in_b = b; b_in_tag = tag;
  endtask

  localparam int NV = 14;
  logic [3:0]  v_op  [NV];
  logic [31:0] v_a   [NV];
  logic [31:0] v_b   [NV];
  logic [31:0] v_exp [NV];
  logic        v_ovf [NV];

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    v_op  = '{OP_SUB, OP_SRA, OP_SLTU, OP_SLT, OP_SLL, OP_SRL, OP_AP4, OP_SUB, OP_OUTB,
              4'hC, OP_AND, OP_OR, OP_SUB, OP_ADD};
    v_a   = '{32'h5, 32'h80000000, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h7FFFFFFC,
              32'h80000000, 32'h0, 32'h5, 32'hF0F0F0F0, 32'h0F, 32'h1, 32'hFFFFFFFF};
    v_b   = '{32'h5, 32'h4, 32'hFFFFFFFF, 32'h1, 32'h23, 32'd31, 32'h0, 32'h1, 32'hDEADBEEF,
              32'h6, 32'hFF00FF00, 32'hF0, 32'h2, 32'h1};
    v_exp = '{32'h0, 32'hF8000000, 32'h1, 32'h1, 32'h8, 32'h1, 32'h80000000, 32'h7FFFFFFF,
              32'hDEADBEEF, 32'h0, 32'hF000F000, 32'hFF, 32'hFFFFFFFF, 32'h0};
    v_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    a_in_valid = 0; a_in_op = 0; a_in_a = 0; a_in_b = 0; a_in_tag = 0; a_flush = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_op = 0; b_in_a = 0; b_in_b = 0; b_in_tag = 0; b_flush = 0; b_out_ready = 1;

    #2;
    check("rst_valid", a_out_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_res", a_out_res, 0);
    check("rst_tag", a_out_tag, 0);
    check("rst_zero", a_out_zero, 1);
    check("rst_ovf", a_out_ovf, 0);
    check("rst_ready", a_in_ready, 1);
    check("rst_b_zero", b_out_zero, 1);

    // ADD overflow with exact two-cycle latency; acceptance on the first edge after reset.
    @(negedge clk); rst = 1'b0; drive_a(OP_ADD, 32'h7FFFFFFF, 32'h1, 6'd3);
    @(negedge clk); a_in_valid = 0;
    check("lat_early_valid", a_out_valid, 0);
    check("lat_busy", a_busy, 1);
    @(negedge clk);
    check("add_valid", a_out_valid, 1);
    check("add_res", a_out_res, 32'h80000000);
    check("add_tag", a_out_tag, 3);
    check("add_ovf", a_out_ovf, 1);
    check("add_zero", a_out_zero, 0);

    // Back-to-back stream, one op per cycle.
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        $display("vec %0d op=%0d a=0x%0h b=0x%0h -> res=0x%0h tag=%0d ovf=%0d zero=%0d",
                 i-2, v_op[i-2], v_a[i-2], v_b[i-2], a_out_res, a_out_tag, a_out_ovf, a_out_zero);
        check($sformatf("vec%0d_valid", i-2), a_out_valid, 1);
        check($sformatf("vec%0d_res", i-2), a_out_res, v_exp[i-2]);
        check($sformatf("vec%0d_tag", i-2), a_out_tag, 6'(i-2));
        check($sformatf("vec%0d_ovf", i-2), a_out_ovf, v_ovf[i-2]);
        check($sformatf("vec%0d_zero", i-2), a_out_zero, (v_exp[i-2] == 0));
      end
      if (i < NV) drive_a(v_op[i], v_a[i], v_b[i], 6'(i));
      else a_in_valid = 0;
    end

    // Stall: pipeline full, out_ready low for three edges, pending op held at the input.
    @(negedge clk); a_out_ready = 0; drive_a(OP_ADD, 32'd1, 32'd2, 6'd1);
    @(negedge clk); drive_a(OP_XOR, 32'hF0, 32'h0F, 6'd2);
    @(negedge clk); drive_a(OP_OR, 32'h30, 32'h03, 6'd3);
    check("stall_valid", a_out_valid, 1);
    check("stall_ready", a_in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_res", k), a_out_res, 32'd3);
      check($sformatf("stall%0d_tag", k), a_out_tag, 1);
      check($sformatf("stall%0d_ready", k), a_in_ready, 0);
    end
    a_out_ready = 1;
    @(negedge clk); a_in_valid = 0;
    check("rel1_tag", a_out_tag, 2);
    check("rel1_res", a_out_res, 32'hFF);
    @(negedge clk);
    check("rel2_tag", a_out_tag, 3);
    check("rel2_res", a_out_res, 32'h33);
    check("rel2_valid", a_out_valid, 1);
    @(negedge clk);
    check("rel3_valid", a_out_valid, 0);
    check("rel3_busy", a_busy, 0);

    // Flush with two ops in flight and a third presented in the flush cycle.
    @(negedge clk); drive_a(OP_ADD, 32'd10, 32'd20, 6'd8);
    @(negedge clk); drive_a(OP_ADD, 32'd1, 32'd1, 6'd9);
    @(negedge clk); drive_a(OP_ADD, 32'd2, 32'd2, 6'd10); a_flush = 1;
    check("flush_deliver_tag", a_out_tag, 8);
    check("flush_deliver_valid", a_out_valid, 1);
    @(negedge clk); a_flush = 0; a_in_valid = 0;
    check("flush_valid1", a_out_valid, 0);
    check("flush_busy", a_busy, 0);
    @(negedge clk);
    check("flush_valid2", a_out_valid, 0);

    // Asynchronous reset in the middle of a stall.
    @(negedge clk); a_out_ready = 0; drive_a(OP_AND, 32'hFF, 32'h0F, 6'd5);
    @(negedge clk); a_in_valid = 0;
    @(negedge clk);
    check("pre_rst_valid", a_out_valid, 1);
    check("pre_rst_res", a_out_res, 32'h0F);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", a_out_valid, 0);
    check("async_rst_busy", a_busy, 0);
    check("async_rst_ready", a_in_ready, 1);
    check("async_rst_res", a_out_res, 0);
    @(negedge clk); rst = 1'b0; a_out_ready = 1; drive_a(OP_SLT, 32'hFFFFFFFF, 32'h1, 6'd7);
    @(negedge clk); a_in_valid = 0;
    check("post_rst_early", a_out_valid, 0);
    @(negedge clk);
    check("post_rst_valid", a_out_valid, 1);
    check("post_rst_res", a_out_res, 1);
    check("post_rst_tag", a_out_tag, 7);

    // 64-bit, single-cycle instance.
    @(negedge clk); drive_b(OP_SLL, 64'h1, 64'd63, 6'd1);
    @(negedge clk);
    check("b_sll_valid", b_out_valid, 1);
    check("b_sll_res", b_out_res, 64'h8000000000000000);
    drive_b(OP_AP4, 64'hFFFFFFFFFFFFFFFC, 64'h0, 6'd2);
    @(negedge clk);
    check("b_ap4_res", b_out_res, 64'h0);
    check("b_ap4_zero", b_out_zero, 1);
    check("b_ap4_ovf", b_out_ovf, 0);
    check("b_ap4_tag", b_out_tag, 2);
    drive_b(4'hD, 64'h1234, 64'h5678, 6'd3);
    @(negedge clk);
    check("b_undef_res", b_out_res, 64'h0);
    drive_b(OP_SRA, 64'h8000000000000000, 64'd63, 6'd4);
    @(negedge clk);
    check("b_sra_res", b_out_res, 64'hFFFFFFFFFFFFFFFF);
    b_in_valid = 0;
    @(negedge clk);
    check("b_idle_valid", b_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
